// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares one FIFO write port among
// N requesters. A winner holds the port for a burst of up to MAX_BURST words.
// FIFO full stalls the burst, and a grant that stalls too long is revoked.
// Every exit from a burst passes through one IDLE cycle before the next grant.
module fifo_wr_arbiter #(
  parameter int N         = 4,
  parameter int DW        = 5,
  parameter int MAX_BURST = 4,
  parameter int STALL_MAX = 16
) (
  input  logic            w_clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] req_data,
  input  logic            full,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    ack,
  output logic            w_en,
  output logic [DW-1:0]   wdata,
  output logic            busy,
  output logic            stall_err
);

  localparam int PW  = (N > 1) ? $clog2(N) : 1;
  localparam int BCW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t         state_reg;
  logic [N-1:0]   gnt_reg;
  logic           busy_reg;
  logic           stall_err_reg;
  logic [BCW-1:0] burst_cnt_reg;
  logic [7:0]     stall_cnt_reg;
  // Index of the most recent winner; it doubles as the granted index in BURST.
  logic [PW-1:0]  rr_ptr_reg;

  logic           hit;
  logic [PW-1:0]  win_idx;
  logic           win_found;
  logic [PW-1:0]  cand_idx;
  logic [DW-1:0]  slice_masked [N];

  // A word moves only when the granted requester has data, FIFO has room and
  // reset is not asserted (reset may coincide with a still-held grant).
  assign hit       = (|(gnt_reg & req)) & ~full & ~reset;
  assign w_en      = hit;
  assign ack       = gnt_reg & {N{hit}};
  assign gnt       = gnt_reg;
  assign busy      = busy_reg;
  assign stall_err = stall_err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slice
      assign slice_masked[gi] = gnt_reg[gi] ? req_data[gi*DW +: DW] : '0;
    end
  endgenerate

  // OR of one-hot masked slices selects the granted requester's data (0 if none).
  always_comb begin
    wdata = '0;
    for (int i = 0; i < N; i++) begin
      wdata = wdata | slice_masked[i];
    end
  end

  // Round-robin search starting just after the last winner.
  always_comb begin
    win_idx   = rr_ptr_reg;
    win_found = 1'b0;
    cand_idx  = '0;
    for (int k = 1; k <= N; k++) begin
      cand_idx = PW'((int'(rr_ptr_reg) + k) % N);
      if (!win_found && req[cand_idx]) begin
        win_idx   = cand_idx;
        win_found = 1'b1;
      end
    end
  end

  // Grant FSM with registered gnt/busy/stall_err and the burst/stall counters.
  always_ff @(posedge w_clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      gnt_reg       <= '0;
      busy_reg      <= 1'b0;
      stall_err_reg <= 1'b0;
      burst_cnt_reg <= '0;
      stall_cnt_reg <= '0;
      rr_ptr_reg    <= PW'(N - 1);
    end else begin
      stall_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            state_reg     <= BURST;
            gnt_reg       <= N'(1) << win_idx;
            rr_ptr_reg    <= win_idx;
            busy_reg      <= 1'b1;
            burst_cnt_reg <= '0;
            stall_cnt_reg <= '0;
          end
        end
        BURST: begin
          if (hit) begin
            if (burst_cnt_reg == BCW'(MAX_BURST - 1)) begin
              state_reg <= IDLE;
              gnt_reg   <= '0;
              busy_reg  <= 1'b0;
            end else begin
              burst_cnt_reg <= burst_cnt_reg + 1'b1;
              stall_cnt_reg <= '0;
            end
          end else if (!req[rr_ptr_reg]) begin
            // Requester released the port before finishing its burst.
            state_reg <= IDLE;
            gnt_reg   <= '0;
            busy_reg  <= 1'b0;
          end else begin
            // Requester still waiting but FIFO is full.
            if (stall_cnt_reg == 8'(STALL_MAX - 1)) begin
              state_reg     <= IDLE;
              gnt_reg       <= '0;
              busy_reg      <= 1'b0;
              stall_err_reg <= 1'b1;
            end else begin
              stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          gnt_reg   <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-cycle vectors {inputs, expected outputs},
// plus a write scoreboard fed by the vectors and drained by a write monitor.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 5;

  logic            w_clk;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic            full;
  logic [N-1:0]    gnt;
  logic [N-1:0]    ack;
  logic            w_en;
  logic [DW-1:0]   wdata;
  logic            busy;
  logic            stall_err;

  fifo_wr_arbiter #(.N(4), .DW(5), .MAX_BURST(4), .STALL_MAX(16)) dut (
    .w_clk     (w_clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .full      (full),
    .gnt       (gnt),
    .ack       (ack),
    .w_en      (w_en),
    .wdata     (wdata),
    .busy      (busy),
    .stall_err (stall_err)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  typedef struct packed {
    logic         rst;
    logic [N-1:0] rq;
    logic         fl;
    logic [N-1:0] g;
    logic         we;
    logic         b;
    logic         se;
  } vec_t;

  typedef struct packed {
    logic [N-1:0]  a;
    logic [DW-1:0] d;
  } wr_t;

  vec_t vq[$];
  wr_t  sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic [DW-1:0] dvals [N];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] data_of(input logic [N-1:0] g);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < N; i++) if (g[i]) d = dvals[i];
    return d;
  endfunction

  task automatic add(input logic r, input logic [N-1:0] rq, input logic f,
                     input logic [N-1:0] g, input logic we, input logic b, input logic se);
    vec_t v;
    v.rst = r; v.rq = rq; v.fl = f; v.g = g; v.we = we; v.b = b; v.se = se;
    vq.push_back(v);
  endtask

  // Write monitor: every FIFO write must match the next expected word.
  always @(negedge w_clk) begin
    wr_t e;
    if (w_en === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_write", -1, {27'd0, ack, 1'b1}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_ack", -1, 32'(ack), 32'(e.a));
        chk("sb_wdata", -1, 32'(wdata), 32'(e.d));
      end
    end
  end

  initial begin
    logic [N-1:0] g;
    logic [N-1:0] exp_ack;
    wr_t          w;

    dvals[0] = 5'h05; dvals[1] = 5'h0A; dvals[2] = 5'h11; dvals[3] = 5'h1C;
    req_data = {dvals[3], dvals[2], dvals[1], dvals[0]};
    reset = 1'b1; req = '0; full = 1'b0;

    // Reset held two cycles with all requests up.
    add(1, 4'b1111, 0, 4'b0000, 0, 0, 0);
    add(1, 4'b1111, 0, 4'b0000, 0, 0, 0);
    // Single burst for requester 1, then regrant and early release.
    add(0, 4'b0010, 0, 4'b0000, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 4'b0010, 0, 4'b0010, 1, 1, 0);
    add(0, 4'b0010, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b0010, 0, 4'b0010, 1, 1, 0);
    add(0, 4'b0000, 0, 4'b0010, 0, 1, 0);
    // Reset again, then fairness with all four requesting.
    add(1, 4'b0000, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b1111, 0, 4'b0000, 0, 0, 0);
    for (int r = 0; r < 5; r++) begin
      g = 4'b0001 << (r % 4);
      for (int k = 0; k < 4; k++) add(0, 4'b1111, 0, g, 1, 1, 0);
      add(0, (r == 4) ? 4'b0000 : 4'b1111, 0, 4'b0000, 0, 0, 0);
    end
    // Back-pressure: full for 3 cycles after the 2nd word of requester 1.
    add(0, 4'b0010, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b0010, 0, 4'b0010, 1, 1, 0);
    add(0, 4'b0010, 0, 4'b0010, 1, 1, 0);
    for (int k = 0; k < 3; k++) add(0, 4'b0010, 1, 4'b0010, 0, 1, 0);
    add(0, 4'b0010, 0, 4'b0010, 1, 1, 0);
    add(0, 4'b0010, 0, 4'b0010, 1, 1, 0);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    // Stall revoke: requester 0 held off by full for 16 cycles.
    add(0, 4'b0001, 1, 4'b0000, 0, 0, 0);
    for (int k = 0; k < 16; k++) add(0, 4'b0001, 1, 4'b0001, 0, 1, 0);
    add(0, 4'b0000, 1, 4'b0000, 0, 0, 1);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    // Early release of requester 2 after two words; requester 3 next.
    add(0, 4'b1100, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b1100, 0, 4'b0100, 1, 1, 0);
    add(0, 4'b1100, 0, 4'b0100, 1, 1, 0);
    add(0, 4'b1000, 0, 4'b0100, 0, 1, 0);
    add(0, 4'b1000, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b1000, 0, 4'b1000, 1, 1, 0);
    // Reset mid-burst: write blocked at once, grant gone after the edge.
    add(1, 4'b1000, 0, 4'b1000, 0, 1, 0);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b1001, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b1001, 0, 4'b0001, 1, 1, 0);
    add(0, 4'b0000, 0, 4'b0001, 0, 1, 0);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);

    @(posedge w_clk);
    #1;
    foreach (vq[i]) begin
      reset = vq[i].rst;
      req   = vq[i].rq;
      full  = vq[i].fl;
      #3;
      exp_ack = vq[i].we ? vq[i].g : 4'b0000;
      chk("gnt", i, 32'(gnt), 32'(vq[i].g));
      chk("w_en", i, 32'(w_en), 32'(vq[i].we));
      chk("ack", i, 32'(ack), 32'(exp_ack));
      chk("busy", i, 32'(busy), 32'(vq[i].b));
      chk("stall_err", i, 32'(stall_err), 32'(vq[i].se));
      chk("wdata", i, 32'(wdata), 32'(data_of(vq[i].g)));
      if (vq[i].we) begin
        w.a = vq[i].g;
        w.d = data_of(vq[i].g);
        sb.push_back(w);
      end
      $display("vec %0d rst=%0b req=%b full=%0b gnt=%b w_en=%0b wdata=%h busy=%0b stall_err=%0b",
               i, reset, req, full, gnt, w_en, wdata, busy, stall_err);
      @(posedge w_clk);
      #1;
    end
    @(posedge w_clk);
    #1;
    chk("sb_pending_words", vq.size(), 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
